// File: rtl/alu_if.sv
// Operand/result bundle between the datapath controller and the ALU.
// The master drives operands and opcode; the ALU returns registered results and flags.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       op;
    logic             cf;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] c;
    logic             c_flag;
    logic             o_flag;
    logic             z_flag;

    modport master (
        output a, b, op, cf,
        input  acc, c, c_flag, o_flag, z_flag
    );

    modport slave (
        input  a, b, op, cf,
        output acc, c, c_flag, o_flag, z_flag
    );
endinterface

// File: rtl/alu.sv
// Registered arithmetic/logic unit: one op per cycle, results and flags one edge after sampling.
// NOP, CMP and undefined opcodes leave the result registers untouched.
module alu #(
    parameter int WIDTH = 16
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [7:0] {
        OP_NOP = 8'h00,
        OP_ADD = 8'h01,
        OP_ADC = 8'h02,
        OP_SUB = 8'h03,
        OP_SBB = 8'h04,
        OP_MUL = 8'h05,
        OP_DIV = 8'h06,
        OP_AND = 8'h07,
        OP_OR  = 8'h08,
        OP_XOR = 8'h09,
        OP_NOT = 8'h0A,
        OP_SHL = 8'h0B,
        OP_SHR = 8'h0C,
        OP_SAR = 8'h0D,
        OP_INC = 8'h0E,
        OP_DEC = 8'h0F,
        OP_CMP = 8'h10,
        OP_NEG = 8'h11
    } op_e;

    logic [WIDTH-1:0]   as_x;
    logic [WIDTH-1:0]   as_y;
    logic               as_ci;
    logic               as_sub;
    logic [WIDTH:0]     as_raw;
    logic [WIDTH-1:0]   as_res;
    logic               as_carry;
    logic               as_ovf;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     shl_raw;
    logic [WIDTH:0]     shr_raw;
    logic [WIDTH:0]     sar_raw;

    logic [WIDTH-1:0]   next_acc;
    logic [WIDTH-1:0]   next_c;
    logic               next_cf;
    logic               next_of;
    logic               next_zf;

    // All add/subtract-family ops share one adder; NEG is 0 - a so its borrow means a != 0.
    always_comb begin
        as_x   = bus.a;
        as_y   = bus.b;
        as_ci  = 1'b0;
        as_sub = 1'b0;
        case (bus.op)
            OP_ADC:         as_ci = bus.cf;
            OP_SUB, OP_CMP: as_sub = 1'b1;
            OP_SBB: begin
                as_sub = 1'b1;
                as_ci  = bus.cf;
            end
            OP_INC:         as_y = ONE;
            OP_DEC: begin
                as_y   = ONE;
                as_sub = 1'b1;
            end
            OP_NEG: begin
                as_x   = '0;
                as_y   = bus.a;
                as_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (as_sub) begin
            as_raw = {1'b0, as_x} - {1'b0, as_y} - {{WIDTH{1'b0}}, as_ci};
        end else begin
            as_raw = {1'b0, as_x} + {1'b0, as_y} + {{WIDTH{1'b0}}, as_ci};
        end
        as_res   = as_raw[WIDTH-1:0];
        as_carry = as_raw[WIDTH];
        if (as_sub) begin
            as_ovf = (as_x[WIDTH-1] != as_y[WIDTH-1]) && (as_res[WIDTH-1] != as_x[WIDTH-1]);
        end else begin
            as_ovf = (as_x[WIDTH-1] == as_y[WIDTH-1]) && (as_res[WIDTH-1] != as_x[WIDTH-1]);
        end
    end

    // Shifts run one bit wider so the last bit shifted out lands in the extra position.
    always_comb begin
        amt       = bus.b[SHW-1:0];
        product   = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        quotient  = (bus.b == '0) ? '1 : bus.a / bus.b;
        remainder = (bus.b == '0) ? bus.a : bus.a % bus.b;
        shl_raw   = {1'b0, bus.a} << amt;
        shr_raw   = {bus.a, 1'b0} >> amt;
        sar_raw   = $signed({bus.a, 1'b0}) >>> amt;
    end

    always_comb begin
        next_acc = bus.acc;
        next_c   = bus.c;
        next_cf  = bus.c_flag;
        next_of  = bus.o_flag;
        next_zf  = bus.z_flag;
        case (bus.op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC, OP_NEG: begin
                next_acc = as_res;
                next_c   = '0;
                next_cf  = as_carry;
                next_of  = as_ovf;
                next_zf  = (as_res == '0);
            end
            OP_CMP: begin
                next_cf = as_carry;
                next_of = as_ovf;
                next_zf = (as_res == '0);
            end
            OP_MUL: begin
                next_acc = product[WIDTH-1:0];
                next_c   = product[2*WIDTH-1:WIDTH];
                next_cf  = |product[2*WIDTH-1:WIDTH];
                next_of  = |product[2*WIDTH-1:WIDTH];
                next_zf  = (product[WIDTH-1:0] == '0);
            end
            OP_DIV: begin
                next_acc = quotient;
                next_c   = remainder;
                next_cf  = (bus.b == '0);
                next_of  = 1'b0;
                next_zf  = (bus.b != '0) && (quotient == '0);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (bus.op)
                    OP_AND:  next_acc = bus.a & bus.b;
                    OP_OR:   next_acc = bus.a | bus.b;
                    OP_XOR:  next_acc = bus.a ^ bus.b;
                    default: next_acc = ~bus.a;
                endcase
                next_c  = '0;
                next_cf = 1'b0;
                next_of = 1'b0;
                next_zf = (next_acc == '0);
            end
            OP_SHL: begin
                next_acc = shl_raw[WIDTH-1:0];
                next_c   = '0;
                next_cf  = shl_raw[WIDTH];
                next_of  = 1'b0;
                next_zf  = (shl_raw[WIDTH-1:0] == '0);
            end
            OP_SHR: begin
                next_acc = shr_raw[WIDTH:1];
                next_c   = '0;
                next_cf  = shr_raw[0];
                next_of  = 1'b0;
                next_zf  = (shr_raw[WIDTH:1] == '0);
            end
            OP_SAR: begin
                next_acc = sar_raw[WIDTH:1];
                next_c   = '0;
                next_cf  = sar_raw[0];
                next_of  = 1'b0;
                next_zf  = (sar_raw[WIDTH:1] == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.acc    <= '0;
            bus.c      <= '0;
            bus.c_flag <= 1'b0;
            bus.o_flag <= 1'b0;
            bus.z_flag <= 1'b0;
        end else begin
            bus.acc    <= next_acc;
            bus.c      <= next_c;
            bus.c_flag <= next_cf;
            bus.o_flag <= next_of;
            bus.z_flag <= next_zf;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: each task runs a table of ops, one per cycle,
// and compares {acc, c, c_flag, o_flag, z_flag} against hand-computed values.
module tb_alu;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    alu_if #(.WIDTH(16)) bus ();

    alu #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [34:0] obs;
    assign obs = {bus.acc, bus.c, bus.c_flag, bus.o_flag, bus.z_flag};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op;
        logic        cf;
        logic [34:0] exp;
    } vec_t;

    // flags packed as {c_flag, o_flag, z_flag}
    function automatic vec_t mk(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic [7:0] op, input logic cf, input logic [15:0] acc,
                                input logic [15:0] c, input logic [2:0] fl);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.b    = b;
        v.op   = op;
        v.cf   = cf;
        v.exp  = {acc, c, fl};
        return v;
    endfunction

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                        input logic cf);
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
        bus.cf = cf;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input vec_t q[$]);
        foreach (q[i]) begin
            step(q[i].a, q[i].b, q[i].op, q[i].cf);
            tests_run++;
            if (obs !== q[i].exp) begin
                tests_failed++;
                $display("[TB] FAIL %s: got acc=%h c=%h cf,of,zf=%b expected acc=%h c=%h cf,of,zf=%b",
                         q[i].name, obs[34:19], obs[18:3], obs[2:0],
                         q[i].exp[34:19], q[i].exp[18:3], q[i].exp[2:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.a  = 16'h1111;
        bus.b  = 16'h2222;
        bus.op = 8'h01;
        bus.cf = 1'b0;
        #12;
        tests_run++;
        if (obs !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 35'd0);
        end
        bus.op = 8'h00;
        rst_n  = 1'b1;
        #5;
    endtask

    task automatic test_add();
        vec_t q[$];
        q.push_back(mk("adc_basic",  16'h000A, 16'h000B, 8'h02, 1'b1, 16'h0016, 16'h0000, 3'b000));
        q.push_back(mk("add_wrap",   16'hFFFF, 16'h0001, 8'h01, 1'b0, 16'h0000, 16'h0000, 3'b101));
        q.push_back(mk("add_ovf",    16'h7FFF, 16'h0001, 8'h01, 1'b0, 16'h8000, 16'h0000, 3'b010));
        q.push_back(mk("adc_cf0",    16'h0001, 16'h0002, 8'h02, 1'b0, 16'h0003, 16'h0000, 3'b000));
        q.push_back(mk("inc_ovf",    16'h7FFF, 16'h0000, 8'h0E, 1'b0, 16'h8000, 16'h0000, 3'b010));
        q.push_back(mk("inc_wrap",   16'hFFFF, 16'h0000, 8'h0E, 1'b0, 16'h0000, 16'h0000, 3'b101));
        run_table(q);
    endtask

    task automatic test_sub();
        vec_t q[$];
        q.push_back(mk("sub_borrow", 16'h0005, 16'h0007, 8'h03, 1'b0, 16'hFFFE, 16'h0000, 3'b100));
        q.push_back(mk("cmp_equal",  16'h1234, 16'h1234, 8'h10, 1'b0, 16'hFFFE, 16'h0000, 3'b001));
        q.push_back(mk("sbb_borrow", 16'h0005, 16'h0005, 8'h04, 1'b1, 16'hFFFF, 16'h0000, 3'b100));
        q.push_back(mk("sbb_ovf",    16'h8000, 16'h0000, 8'h04, 1'b1, 16'h7FFF, 16'h0000, 3'b010));
        q.push_back(mk("dec_zero",   16'h0000, 16'h0000, 8'h0F, 1'b0, 16'hFFFF, 16'h0000, 3'b100));
        q.push_back(mk("neg_8000",   16'h8000, 16'h0000, 8'h11, 1'b0, 16'h8000, 16'h0000, 3'b110));
        q.push_back(mk("neg_zero",   16'h0000, 16'h0000, 8'h11, 1'b0, 16'h0000, 16'h0000, 3'b001));
        q.push_back(mk("cmp_less",   16'h0005, 16'h0007, 8'h10, 1'b0, 16'h0000, 16'h0000, 3'b100));
        run_table(q);
    endtask

    task automatic test_mul_div();
        vec_t q[$];
        q.push_back(mk("mul_high",   16'h1234, 16'h0100, 8'h05, 1'b0, 16'h3400, 16'h0012, 3'b110));
        q.push_back(mk("div_basic",  16'h0064, 16'h0007, 8'h06, 1'b0, 16'h000E, 16'h0002, 3'b000));
        q.push_back(mk("div_zero",   16'h0064, 16'h0000, 8'h06, 1'b0, 16'hFFFF, 16'h0064, 3'b100));
        q.push_back(mk("mul_small",  16'h0003, 16'h0004, 8'h05, 1'b0, 16'h000C, 16'h0000, 3'b000));
        q.push_back(mk("div_q_zero", 16'h0003, 16'h0007, 8'h06, 1'b0, 16'h0000, 16'h0003, 3'b001));
        run_table(q);
    endtask

    task automatic test_logic();
        vec_t q[$];
        q.push_back(mk("and",        16'hF0F0, 16'hFF00, 8'h07, 1'b0, 16'hF000, 16'h0000, 3'b000));
        q.push_back(mk("or",         16'hF0F0, 16'hFF00, 8'h08, 1'b0, 16'hFFF0, 16'h0000, 3'b000));
        q.push_back(mk("xor",        16'hF0F0, 16'hFF00, 8'h09, 1'b0, 16'h0FF0, 16'h0000, 3'b000));
        q.push_back(mk("not",        16'hF0F0, 16'h0000, 8'h0A, 1'b0, 16'h0F0F, 16'h0000, 3'b000));
        q.push_back(mk("and_zero",   16'h0F0F, 16'hF0F0, 8'h07, 1'b0, 16'h0000, 16'h0000, 3'b001));
        run_table(q);
    endtask

    task automatic test_shifts();
        vec_t q[$];
        q.push_back(mk("shl_1",      16'h8001, 16'h0001, 8'h0B, 1'b0, 16'h0002, 16'h0000, 3'b100));
        q.push_back(mk("shr_1",      16'h8001, 16'h0001, 8'h0C, 1'b0, 16'h4000, 16'h0000, 3'b100));
        q.push_back(mk("sar_1",      16'h8001, 16'h0001, 8'h0D, 1'b0, 16'hC000, 16'h0000, 3'b100));
        q.push_back(mk("sar_15",     16'h8000, 16'h000F, 8'h0D, 1'b0, 16'hFFFF, 16'h0000, 3'b000));
        q.push_back(mk("shl_0",      16'h1234, 16'h0000, 8'h0B, 1'b0, 16'h1234, 16'h0000, 3'b000));
        q.push_back(mk("shr_b_hi",   16'h1234, 16'h0010, 8'h0C, 1'b0, 16'h1234, 16'h0000, 3'b000));
        q.push_back(mk("shl_15",     16'h0001, 16'h000F, 8'h0B, 1'b0, 16'h8000, 16'h0000, 3'b000));
        q.push_back(mk("shr_out",    16'h0001, 16'h0001, 8'h0C, 1'b0, 16'h0000, 16'h0000, 3'b101));
        run_table(q);
    endtask

    task automatic test_nop_hold();
        vec_t q[$];
        q.push_back(mk("mul_max",    16'hFFFF, 16'hFFFF, 8'h05, 1'b0, 16'h0001, 16'hFFFE, 3'b110));
        q.push_back(mk("nop_hold",   16'h0000, 16'h0000, 8'h00, 1'b1, 16'h0001, 16'hFFFE, 3'b110));
        q.push_back(mk("undef_55",   16'h0000, 16'h0000, 8'h55, 1'b0, 16'h0001, 16'hFFFE, 3'b110));
        q.push_back(mk("undef_ff",   16'h1111, 16'h2222, 8'hFF, 1'b0, 16'h0001, 16'hFFFE, 3'b110));
        run_table(q);
    endtask

    task automatic test_reset_midop();
        vec_t q[$];
        q.push_back(mk("pre_reset_add", 16'h0001, 16'h0001, 8'h01, 1'b0, 16'h0002, 16'h0000, 3'b000));
        run_table(q);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h expected %h", obs, 35'd0);
        end
        step(16'h0005, 16'h0005, 8'h01, 1'b0);
        tests_run++;
        if (obs !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_discard: got %h expected %h", obs, 35'd0);
        end
        bus.op = 8'h00;
        rst_n  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(16'h0005, 16'h0005, 8'h00, 1'b0);
            tests_run++;
            if (obs !== 35'd0) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_nop%0d: got %h expected %h", i, obs, 35'd0);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul_div();
        test_logic();
        test_shifts();
        test_nop_hold();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit registered arithmetic/logic unit for the CPU datapath.
- Takes two operands `a` and `b`, an 8-bit opcode and an incoming carry `cf`.
- Produces a primary result `acc`, a secondary result `c` (multiply high word / divide remainder) and carry/overflow/zero flags.
- All outputs update on the rising clock edge, one cycle after inputs are sampled.

Parameters:
- WIDTH, 16, operand/result width. All widths below assume 16.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  16  operand A.
- b  input  16  operand B; shift amount in b[3:0] for shift ops.
- op  input  8  opcode.
- cf  input  1  carry/borrow in, used by ADC/SBB.
- acc  output  16  primary result (registered).
- c  output  16  secondary result (registered).
- c_flag  output  1  carry/borrow/shift-out flag (registered).
- o_flag  output  1  signed overflow flag (registered).
- z_flag  output  1  zero flag (registered).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): acc=0, c=0, c_flag=0, o_flag=0, z_flag=0. On release, the first rising edge performs a normal operation.
- Latency: inputs sampled at rising edge N; results visible after edge N. Fully pipelined; a new op every cycle; no handshake.
- Opcodes (hex):
  - 00 NOP: all outputs hold.
  - 01 ADD: acc=a+b.
  - 02 ADC: acc=a+b+cf.
  - 03 SUB: acc=a-b.
  - 04 SBB: acc=a-b-cf.
  - 05 MUL: unsigned 32-bit product; acc=low 16 bits, c=high 16 bits.
  - 06 DIV: unsigned; acc=a/b, c=a%b.
  - 07 AND, 08 OR, 09 XOR: bitwise on a,b.
  - 0A NOT: acc=~a.
  - 0B SHL, 0C SHR (logical), 0D SAR (arithmetic): a shifted by b[3:0].
  - 0E INC: acc=a+1.
  - 0F DEC: acc=a-1.
  - 10 CMP: flags as SUB; acc and c hold.
  - 11 NEG: acc=0-a.
  - All other opcodes behave as NOP.
- Result c is 0 for every op except MUL, DIV and NOP/CMP/undefined (which hold).
- c_flag:
  - ADD/ADC/INC: carry out of bit 15.
  - SUB/SBB/DEC/CMP/NEG: borrow (1 when unsigned a < subtrahend including borrow-in; NEG: 1 when a≠0).
  - MUL: 1 if high word ≠0.
  - DIV: 1 only on divide-by-zero.
  - Shifts: last bit shifted out; 0 when shift amount is 0.
  - Logic ops: 0.
- o_flag:
  - Two's-complement signed overflow for ADD/ADC/SUB/SBB/INC/DEC/CMP/NEG (e.g. INC 7FFF, NEG 8000).
  - MUL: equals c_flag.
  - All others: 0.
- z_flag: 1 when the new acc value is 0. CMP: 1 when a==b.
- Divide by zero (b=0): acc=FFFF, c=a, c_flag=1, o_flag=0, z_flag=0. No trap.
- Wrap-around: all sums and differences are modulo 2^16.
- Shift amount 0: acc=a. Shift amount 15: SAR acc = sign fill.
- Reset asserted mid-operation: outputs clear immediately; the in-flight op is discarded.

Test Plan:
- a=000A, b=000B, op=02, cf=1, rst_n=1 -> after next edge: acc=0016, c=0000, c_flag=0, o_flag=0, z_flag=0.
- a=FFFF, b=0001, op=01 -> acc=0000, c_flag=1, z_flag=1, o_flag=0. Then a=7FFF, b=0001, op=01 -> acc=8000, o_flag=1, c_flag=0.
- a=0005, b=0007, op=03 -> acc=FFFE, c_flag=1, z_flag=0. Then op=10 with a=b=1234 -> z_flag=1, acc unchanged.
- a=1234, b=0100, op=05 -> acc=3400, c=0012, c_flag=1, o_flag=1. Then a=0064, b=0007, op=06 -> acc=000E, c=0002. Then b=0000 -> acc=FFFF, c=0064, c_flag=1.
- a=8001, b=0001: op=0B -> acc=0002, c_flag=1; op=0C -> acc=4000, c_flag=1; op=0D -> acc=C000, c_flag=1.
- Execute op=01 with nonzero result, then pull rst_n=0 between clock edges -> all outputs 0 immediately. Hold op=00 after release -> outputs stay 0.
